// File: rtl/tt_um_seq_alu_if.sv
// TinyTapeout harness bus for tt_um_seq_alu: enable, operand/strobe inputs and
// the result/status outputs, grouped so the tile and its harness share one bundle.
interface tt_um_seq_alu_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_seq_alu.sv
// Byte-serial multi-cycle ALU tile: load A/B over ui_in, execute, stream result + flags.
// Optional macro ALU_MUL_EN builds op 111 as an iterative shift-add multiplier.
module tt_um_seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  tt_um_seq_alu_if.slave bus
);
  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned CW = $clog2(2 * NB + 1);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(2 * NB);
  localparam logic [CW-1:0] CNT_FLAG = CW'(NB);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_RESULT} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
  } op_e;

  logic wr, start, rd_ack;
  assign wr     = bus.uio_in[0];
  assign start  = bus.uio_in[4];
  assign rd_ack = bus.uio_in[5];

  logic unused_bits;
  assign unused_bits = ^bus.uio_in[7:6];

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [7:0]       flags_q, flags_d;
  logic [7:0]       uo_q, uo_d;
  logic             busy_q, busy_d, valid_q, valid_d;

  logic [WIDTH-1:0] alu_res;
  logic [7:0]       alu_flags;
  logic [WIDTH:0]   sum, dif;
  logic             carry, ovf, illegal;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mhi_q, mhi_d, mlo_q, mlo_d;
  logic [SW-1:0]    mcnt_q, mcnt_d;
  logic [WIDTH:0]   msum;

  // {mhi,mlo} starts as {0,B}; each step adds A into the high half and shifts right.
  always_comb begin
    msum = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, a_q} : '0);
  end
`endif

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    dif     = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        carry   = sum[WIDTH];
        ovf     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif[WIDTH-1:0];
        carry   = dif[WIDTH];
        ovf     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SHL:  alu_res = a_q << b_q[SW-1:0];
      OP_SHR:  alu_res = a_q >> b_q[SW-1:0];
      default: illegal = 1'b1;
    endcase
    alu_flags = {3'b000, illegal, alu_res[WIDTH-1], ovf, carry, ~|alu_res};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
`ifdef ALU_MUL_EN
    mhi_d   = mhi_q;
    mlo_d   = mlo_q;
    mcnt_d  = mcnt_q;
`endif
    if (bus.ena) begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (wr) begin
            if (cnt_q != CNT_FULL) begin
              for (int unsigned i = 0; i < NB; i++) begin
                if (cnt_q == CW'(i))      a_d[8*i +: 8] = bus.ui_in;
                if (cnt_q == CW'(NB + i)) b_d[8*i +: 8] = bus.ui_in;
              end
              cnt_d   = cnt_q + 1'b1;
              state_d = S_LOAD;
            end
          end else if (start && (cnt_q == CNT_FULL)) begin
            op_d    = op_e'(bus.uio_in[3:1]);
            state_d = S_EXEC;
`ifdef ALU_MUL_EN
            mhi_d   = '0;
            mlo_d   = b_q;
            mcnt_d  = '0;
`endif
          end
        end
        S_EXEC: begin
`ifdef ALU_MUL_EN
          if (op_q == OP_MUL) begin
            mhi_d  = msum[WIDTH:1];
            mlo_d  = {msum[0], mlo_q[WIDTH-1:1]};
            mcnt_d = mcnt_q + 1'b1;
            if (mcnt_q == SW'(WIDTH - 1)) begin
              res_d   = mlo_d;
              flags_d = {3'b000, 1'b0, mlo_d[WIDTH-1], 1'b0, |mhi_d, ~|mlo_d};
              state_d = S_RESULT;
              cnt_d   = '0;
            end
          end else begin
            res_d   = alu_res;
            flags_d = alu_flags;
            state_d = S_RESULT;
            cnt_d   = '0;
          end
`else
          res_d   = alu_res;
          flags_d = alu_flags;
          state_d = S_RESULT;
          cnt_d   = '0;
`endif
        end
        S_RESULT: begin
          if (rd_ack) begin
            if (cnt_q == CNT_FLAG) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Status and output byte are registered from the current state, so they trail it by one cycle.
  always_comb begin
    uo_d    = uo_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    if (bus.ena) begin
      busy_d  = (state_q == S_EXEC);
      valid_d = (state_q == S_RESULT);
      uo_d    = '0;
      if (state_q == S_RESULT) begin
        if (cnt_q == CNT_FLAG) begin
          uo_d = flags_q;
        end else begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (cnt_q == CW'(i)) uo_d = res_q[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
      flags_q <= '0;
      uo_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      mhi_q   <= '0;
      mlo_q   <= '0;
      mcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      uo_q    <= uo_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
`ifdef ALU_MUL_EN
      mhi_q   <= mhi_d;
      mlo_q   <= mlo_d;
      mcnt_q  <= mcnt_d;
`endif
    end
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = {valid_q, busy_q, 6'b000000};
  assign bus.uio_oe  = 8'hC0;
endmodule

// File: doc/tt_um_seq_alu.md
# tt_um_seq_alu

Parametrised, multi-cycle ALU tile for the TinyTapeout harness: the successor to the 8-bit combinational ALU wrapper. Two WIDTH-bit operands are loaded byte-serially over `ui_in`, an operation is executed (single-cycle, or iterative for multiply), and the result plus a flag byte are streamed back byte-serially on `uo_out` under a simple strobe/ack handshake. It sits directly under the harness and is the integer datapath front-end for the team's wider floating-point work.

## Interface
- `WIDTH`, 32, operand/result width in bits; multiple of 8, range 8..64. NB = WIDTH/8.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  tile enable; when 0 all strobes are ignored and state is held.
- `ui_in`  in  8  operand byte.
- `uio_in`  in  8  [0] wr (byte valid), [3:1] op, [4] start, [5] rd_ack; [7:6] unused.
- `uo_out`  out  8  current result/flag byte; 0 outside RESULT.
- `uio_out`  out  8  [6] busy, [7] res_valid, [5:0] = 0.
- `uio_oe`  out  8  constant 8'hC0.

## Operation
- States: IDLE, LOAD, EXEC, RESULT. Byte counter `cnt` (0..2·NB).
- IDLE/LOAD: each cycle with wr=1 stores `ui_in` into byte `cnt` (A bytes LS-first, then B LS-first), cnt++ ; first wr moves IDLE→LOAD. wr when cnt=2·NB is ignored.
- start=1 with cnt=2·NB: latch op, →EXEC. start with cnt<2·NB ignored. start and wr in same cycle: wr is processed, start ignored.
- Ops: 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 SHL (A << B[log2 WIDTH−1:0]), 110 SHR logical, 111 MUL (see Configuration). Result truncated to WIDTH bits.
- Flag byte: [0] zero (result==0), [1] carry (ADD carry-out; SUB borrow, i.e. A<B unsigned; else 0), [2] signed overflow (ADD/SUB only), [3] result MSB, [4] illegal op, [7:5] = 0.
- RESULT: `uo_out` = result byte `cnt` (LS first) for cnt<NB, flag byte at cnt=NB. rd_ack=1 advances; rd_ack on flag byte →IDLE, cnt=0, operands retained but must be reloaded (next wr restarts at byte 0).
- wr/start ignored outside IDLE/LOAD; rd_ack ignored outside RESULT.

## Timing
- Reset: state IDLE, cnt=0, operand/result/flag registers 0, `uo_out`=0, busy=0, res_valid=0. Reset mid-operation aborts immediately, no partial result visible.
- busy=1 exactly while in EXEC; res_valid=1 exactly while in RESULT; both registered.
- Ops 000–110: start sampled at edge k → EXEC for one cycle → res_valid=1 after edge k+2, result byte 0 on `uo_out` same cycle.
- MUL: WIDTH iteration cycles; res_valid=1 after edge k+WIDTH+1.
- `uo_out` registered; new byte visible the cycle after the rd_ack edge.
- ena=0 freezes everything including MUL iterations.

## Configuration
- `ALU_MUL_EN` defined: op 111 = iterative shift-add unsigned multiply, low WIDTH bits of product, one bit per cycle; carry flag = 1 if upper product bits nonzero.
- Not defined: op 111 completes in one cycle like other ops, result 0, flags = 8'h11 (illegal + zero); no multiplier logic synthesised.

## Test plan
- WIDTH=32: load A=32'hFFFF_FFFF, B=1, op ADD, start → bytes 00,00,00,00 then flag 8'h03 (zero+carry); busy for exactly one cycle.
- SUB A=5, B=7 → result 32'hFFFF_FFFE streamed FE,FF,FF,FF; flag 8'h0A (borrow+MSB). ADD 32'h7FFF_FFFF+1 → flag bit2=1.
- SHL A=1, B=35 (shift 3) → 8; SHR A=32'h8000_0000, B=31 → 1; start with cnt=7 ignored (busy stays 0).
- With `ALU_MUL_EN`: A=32'h0001_0000 × B=32'h0001_0001 → 32'h0001_0000, carry=1, res_valid exactly WIDTH+1 edges after start; without macro → 0, flag 8'h11.
- Assert rst_n low during MUL iteration and during RESULT byte 2 → all outputs 0 immediately; subsequent full transaction correct.
- ena=0 for 5 cycles mid-load with wr toggling → no bytes captured; resumes correctly when ena=1.
